alu_core: RTL and testbench

// - Registered 16-bit integer ALU for the CS3710 CR16-style datapath; sits between register-file read ports and writeback/PSR.
// - Decodes opcode/opext, computes result S and flag vector CLFZN, registers both on clk.
// - Fully deterministic for every input code (undefined codes included), so the behavioural and synthesised builds match bit-for-bit.

---
 rtl/alu_core.sv | 134 +++++++++++++
 tb/tb_alu_core.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// ============================================================================
//  Module   : alu_core
//  Purpose  : Registered 16-bit CR16-style integer ALU producing result S and
//             flag vector CLFZN one clock after operands are presented.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  opcode,
  input  logic [3:0]  opext,
  input  logic        carry,
  output logic [15:0] S,
  output logic [4:0]  CLFZN
);

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // Register-op opext values double as the immediate-form opcodes.
  localparam logic [3:0] FN_AND  = 4'b0001;
  localparam logic [3:0] FN_OR   = 4'b0010;
  localparam logic [3:0] FN_XOR  = 4'b0011;
  localparam logic [3:0] FN_ADD  = 4'b0101;
  localparam logic [3:0] FN_ADDU = 4'b0110;
  localparam logic [3:0] FN_ADDC = 4'b0111;
  localparam logic [3:0] FN_SUB  = 4'b1001;
  localparam logic [3:0] FN_SUBC = 4'b1010;
  localparam logic [3:0] FN_CMP  = 4'b1011;
  localparam logic [3:0] FN_MOV  = 4'b1101;

  localparam logic [3:0] SH_LSH  = 4'b0100;
  localparam logic [3:0] SH_ASHU = 4'b0110;

  logic [3:0]  fn;
  logic        use_cin;
  logic [16:0] sum;
  logic [16:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        lt_u;
  logic        lt_s;
  logic        eq;
  logic [4:0]  amt;
  logic [4:0]  neg_amt;
  logic [15:0] shl;
  logic [15:0] shr_l;
  logic [15:0] shr_a;
  logic [15:0] shift_res;
  logic [15:0] res;
  logic [4:0]  flags;

  assign fn      = (opcode == OP_REG) ? opext : opcode;
  assign use_cin = (fn == FN_ADDC) || (fn == FN_SUBC);

  // 17-bit forms expose carry-out and borrow (A < B+carry) in bit 16.
  assign sum  = {1'b0, A} + {1'b0, B} + {16'h0000, use_cin & carry};
  assign diff = {1'b0, A} - {1'b0, B} - {16'h0000, use_cin & carry};

  assign add_ovf = (A[15] == B[15]) && (sum[15]  != A[15]);
  assign sub_ovf = (A[15] != B[15]) && (diff[15] != A[15]);

  assign lt_u = (A < B);
  assign lt_s = ($signed(A) < $signed(B));
  assign eq   = (A == B);

  // Shift amount is a 5-bit two's complement value; negatives shift right.
  assign amt     = B[4:0];
  assign neg_amt = ~amt + 5'd1;
  assign shl     = A << amt[3:0];
  assign shr_l   = A >> neg_amt;
  assign shr_a   = $signed(A) >>> neg_amt;

  always_comb begin
    shift_res = 16'h0000;
    case (opext)
      SH_LSH:  shift_res = amt[4] ? shr_l : shl;
      SH_ASHU: shift_res = amt[4] ? shr_a : shl;
      default: shift_res = 16'h0000;
    endcase
  end

  always_comb begin
    res   = 16'h0000;
    flags = 5'b00000;
    if (opcode == OP_SHIFT) begin
      res = shift_res;
    end else if (opcode == OP_LUI) begin
      res = {B[7:0], 8'h00};
    end else begin
      case (fn)
        FN_ADD, FN_ADDC: begin
          res   = sum[15:0];
          flags = {sum[16], 1'b0, add_ovf, 1'b0, 1'b0};
        end
        FN_ADDU: res = sum[15:0];
        FN_SUB, FN_SUBC: begin
          res   = diff[15:0];
          flags = {diff[16], 1'b0, sub_ovf, 1'b0, 1'b0};
        end
        FN_CMP: begin
          res   = diff[15:0];
          flags = {1'b0, lt_u, 1'b0, eq, lt_s};
        end
        FN_AND:  res = A & B;
        FN_OR:   res = A | B;
        FN_XOR:  res = A ^ B;
        FN_MOV:  res = B;
        default: begin
          res   = 16'h0000;
          flags = 5'b00000;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S     <= 16'h0000;
      CLFZN <= 5'b00000;
    end else begin
      S     <= res;
      CLFZN <= flags;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
//  Module   : tb_alu_core
//  Purpose  : Directed self-checking bench for alu_core with hand-computed
//             expected results and flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  opcode;
  logic [3:0]  opext;
  logic        carry;
  logic [15:0] S;
  logic [4:0]  CLFZN;

  int checks = 0;
  int errors = 0;

  alu_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .opext  (opext),
    .carry  (carry),
    .S      (S),
    .CLFZN  (CLFZN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] ext,
                        input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_s, input logic [4:0] exp_f);
    @(negedge clk);
    opcode = op;
    opext  = ext;
    A      = a;
    B      = b;
    carry  = cin;
    @(posedge clk);
    #1;
    check({tag, ".S"}, S, exp_s);
    check({tag, ".CLFZN"}, {11'd0, CLFZN}, {11'd0, exp_f});
  endtask

  initial begin
    rst_n  = 1'b0;
    A      = 16'h0000;
    B      = 16'h0000;
    opcode = 4'b0000;
    opext  = 4'b0000;
    carry  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.S", S, 16'h0000);
    check("reset.CLFZN", {11'd0, CLFZN}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Register-form arithmetic
    run_op("add_ovf",  4'b0000, 4'b0101, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b00100);
    run_op("addc",     4'b0000, 4'b0111, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 5'b10000);
    run_op("add_cf",   4'b0000, 4'b0101, 16'h8000, 16'h8000, 1'b1, 16'h0000, 5'b10100);
    run_op("addu",     4'b0000, 4'b0110, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 5'b00000);
    run_op("sub",      4'b0000, 4'b1001, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 5'b10000);
    run_op("sub_ovf",  4'b0000, 4'b1001, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 5'b00100);
    run_op("subc",     4'b0000, 4'b1010, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 5'b10000);
    run_op("cmp_n",    4'b0000, 4'b1011, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 5'b00001);
    run_op("cmp_l",    4'b0000, 4'b1011, 16'h0001, 16'hFFFF, 1'b0, 16'h0002, 5'b01000);
    run_op("cmp_z",    4'b0000, 4'b1011, 16'h1234, 16'h1234, 1'b0, 16'h0000, 5'b00010);
    run_op("and",      4'b0000, 4'b0001, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 5'b00000);
    run_op("xor",      4'b0000, 4'b0011, 16'hF0F0, 16'h3C3C, 1'b0, 16'hCCCC, 5'b00000);
    run_op("mov",      4'b0000, 4'b1101, 16'h1111, 16'h5A5A, 1'b0, 16'h5A5A, 5'b00000);
    run_op("reg_undef",4'b0000, 4'b1111, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 5'b00000);

    // Immediate forms ignore opext; non-carry forms ignore carry
    run_op("addi",     4'b0101, 4'b1111, 16'h0001, 16'h0001, 1'b1, 16'h0002, 5'b00000);
    run_op("subci",    4'b1010, 4'b0000, 16'h0005, 16'h0002, 1'b1, 16'h0002, 5'b00000);
    run_op("andi",     4'b0001, 4'b1111, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 5'b00000);
    run_op("ori",      4'b0010, 4'b0000, 16'hF0F0, 16'h3C3C, 1'b0, 16'hFCFC, 5'b00000);
    run_op("movi",     4'b1101, 4'b0101, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF, 5'b00000);
    run_op("cmpi_z",   4'b1011, 4'b0000, 16'h00FF, 16'h00FF, 1'b0, 16'h0000, 5'b00010);

    // Shifts and LUI
    run_op("lsh_l1",   4'b1000, 4'b0100, 16'h8001, 16'h0001, 1'b0, 16'h0002, 5'b00000);
    run_op("lsh_r1",   4'b1000, 4'b0100, 16'h8001, 16'hFFFF, 1'b0, 16'h4000, 5'b00000);
    run_op("lsh_r16",  4'b1000, 4'b0100, 16'hFFFF, 16'h0010, 1'b0, 16'h0000, 5'b00000);
    run_op("ashu_r4",  4'b1000, 4'b0110, 16'h8000, 16'hFFFC, 1'b0, 16'hF800, 5'b00000);
    run_op("ashu_r16n",4'b1000, 4'b0110, 16'h8000, 16'h0010, 1'b0, 16'hFFFF, 5'b00000);
    run_op("ashu_r16p",4'b1000, 4'b0110, 16'h7FFF, 16'h0010, 1'b0, 16'h0000, 5'b00000);
    run_op("ashu_l15", 4'b1000, 4'b0110, 16'h0001, 16'h000F, 1'b0, 16'h8000, 5'b00000);
    run_op("sh_undef", 4'b1000, 4'b0101, 16'h1234, 16'h0001, 1'b0, 16'h0000, 5'b00000);
    run_op("lui",      4'b1111, 4'b0000, 16'h1234, 16'h00AB, 1'b0, 16'hAB00, 5'b00000);
    run_op("op_undef", 4'b0100, 4'b0101, 16'h7FFF, 16'h0001, 1'b1, 16'h0000, 5'b00000);

    // Asynchronous reset with an ADD pending, then release
    run_op("pre_rst",  4'b0000, 4'b0101, 16'h0001, 16'h0002, 1'b0, 16'h0003, 5'b00000);
    @(negedge clk);
    opcode = 4'b0000;
    opext  = 4'b0101;
    A      = 16'h1000;
    B      = 16'h0234;
    carry  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst.S", S, 16'h0000);
    check("async_rst.CLFZN", {11'd0, CLFZN}, 16'h0000);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.S", S, 16'h1234);
    check("post_rst.CLFZN", {11'd0, CLFZN}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
